// File: rtl/sha256_round_engine.sv
// SHA-256 compression engine: one 512-bit block per operation, ROUNDS_PER_CYCLE rounds per clock.
// Optional digest <= target comparator is built only when SHA_TARGET_CMP_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start; block, chaining value and working vars captured on accept
// RUN     | ROUNDS_PER_CYCLE rounds per edge until 64 rounds are done
// FINAL   | feed-forward add into digest, pulse done, return to IDLE
module sha256_round_engine #(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic         abort,
    input  logic [511:0] block_in,
    input  logic [255:0] h_in,
    input  logic [255:0] target,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest,
    output logic         meets_target
);

    generate
        if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
              ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rpc
            $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    localparam logic [6:0] RND_STEP = 7'(ROUNDS_PER_CYCLE);
    localparam logic [6:0] RND_LAST = 7'(64 - ROUNDS_PER_CYCLE);

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL} state_e;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        rotr = (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        bsig0 = rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        bsig1 = rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        ssig0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        ssig1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_e       state_q, state_d;
    logic [31:0]  st_q  [8];
    logic [31:0]  st_d  [8];
    logic [31:0]  hin_q [8];
    logic [31:0]  hin_d [8];
    logic [31:0]  w_q   [16];
    logic [31:0]  w_d   [16];
    logic [31:0]  cw    [8];
    logic [31:0]  ww    [16];
    logic [6:0]   rnd_q, rnd_d;
    logic [255:0] digest_q, digest_d, dig_sum;
    logic         meets_q, meets_d, done_q, done_d, cmp_le;
    logic [31:0]  t1, t2, wnew;
    logic [5:0]   kidx;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && !abort) state_d = S_RUN;
            S_RUN: begin
                if (abort)                  state_d = S_IDLE;
                else if (rnd_q == RND_LAST) state_d = S_FINAL;
            end
            S_FINAL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != S_IDLE);
        done         = done_q;
        digest       = digest_q;
        meets_target = meets_q;
    end

    // Round cascade: a..h in cw[0..7], ww[0] is W[t]; window slides one word per round.
    always_comb begin
        cw   = st_q;
        ww   = w_q;
        t1   = '0;
        t2   = '0;
        wnew = '0;
        kidx = '0;
        for (int r = 0; r < int'(ROUNDS_PER_CYCLE); r++) begin
            kidx = rnd_q[5:0] + 6'(r);
            t1   = cw[7] + bsig1(cw[4]) + ((cw[4] & cw[5]) ^ (~cw[4] & cw[6])) + K_TAB[kidx] + ww[0];
            t2   = bsig0(cw[0]) + ((cw[0] & cw[1]) ^ (cw[0] & cw[2]) ^ (cw[1] & cw[2]));
            wnew = ssig1(ww[14]) + ww[9] + ssig0(ww[1]) + ww[0];
            for (int i = 7; i > 0; i--) cw[i] = cw[i-1];
            cw[4] = cw[4] + t1;
            cw[0] = t1 + t2;
            for (int i = 0; i < 15; i++) ww[i] = ww[i+1];
            ww[15] = wnew;
        end
    end

    always_comb begin
        dig_sum = '0;
        for (int i = 0; i < 8; i++) dig_sum[255-32*i -: 32] = hin_q[i] + st_q[i];
    end

`ifdef SHA_TARGET_CMP_EN
    assign cmp_le = (dig_sum <= target);
`else
    logic unused_target;
    assign unused_target = ^target;
    assign cmp_le        = 1'b0;
`endif

    always_comb begin
        st_d     = st_q;
        hin_d    = hin_q;
        w_d      = w_q;
        rnd_d    = rnd_q;
        digest_d = digest_q;
        meets_d  = meets_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    rnd_d = '0;
                    for (int i = 0; i < 8; i++) begin
                        st_d[i]  = h_in[255-32*i -: 32];
                        hin_d[i] = h_in[255-32*i -: 32];
                    end
                    for (int i = 0; i < 16; i++) w_d[i] = block_in[511-32*i -: 32];
                end
            end
            S_RUN: begin
                if (!abort) begin
                    st_d  = cw;
                    w_d   = ww;
                    rnd_d = rnd_q + RND_STEP;
                end
            end
            S_FINAL: begin
                if (!abort) begin
                    digest_d = dig_sum;
                    meets_d  = cmp_le;
                    done_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            st_q     <= '{default: '0};
            hin_q    <= '{default: '0};
            w_q      <= '{default: '0};
            rnd_q    <= '0;
            digest_q <= '0;
            meets_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            st_q     <= st_d;
            hin_q    <= hin_d;
            w_q      <= w_d;
            rnd_q    <= rnd_d;
            digest_q <= digest_d;
            meets_q  <= meets_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed bench for sha256_round_engine: known-answer digests at R=1/2/4/8, handshake,
// abort, mid-run reset and the SHA_TARGET_CMP_EN comparison (expectations follow the build).
module tb_sha256_round_engine;

    localparam logic [255:0] IV        = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         n_rst, abort;
    logic         start1, start2, start4, start8;
    logic [511:0] block_in;
    logic [255:0] h_in, target;
    logic         busy1, busy2, busy4, busy8;
    logic         done1, done2, done4, done8;
    logic         meets1, meets2, meets4, meets8;
    logic [255:0] digest1, digest2, digest4, digest8;

    int n_checks = 0;
    int n_fail   = 0;

    sha256_round_engine #(.ROUNDS_PER_CYCLE(1)) dut (
        .clk(clk), .n_rst(n_rst), .start(start1), .abort(abort), .block_in(block_in), .h_in(h_in),
        .target(target), .busy(busy1), .done(done1), .digest(digest1), .meets_target(meets1));
    sha256_round_engine #(.ROUNDS_PER_CYCLE(2)) dut2 (
        .clk(clk), .n_rst(n_rst), .start(start2), .abort(abort), .block_in(block_in), .h_in(h_in),
        .target(target), .busy(busy2), .done(done2), .digest(digest2), .meets_target(meets2));
    sha256_round_engine #(.ROUNDS_PER_CYCLE(4)) dut4 (
        .clk(clk), .n_rst(n_rst), .start(start4), .abort(abort), .block_in(block_in), .h_in(h_in),
        .target(target), .busy(busy4), .done(done4), .digest(digest4), .meets_target(meets4));
    sha256_round_engine #(.ROUNDS_PER_CYCLE(8)) dut8 (
        .clk(clk), .n_rst(n_rst), .start(start8), .abort(abort), .block_in(block_in), .h_in(h_in),
        .target(target), .busy(busy8), .done(done8), .digest(digest8), .meets_target(meets8));

    task automatic set_start(input int rpc, input logic v);
        case (rpc)
            1:       start1 = v;
            2:       start2 = v;
            4:       start4 = v;
            default: start8 = v;
        endcase
    endtask

    function automatic logic sel_done(input int rpc);
        case (rpc)
            1:       return done1;
            2:       return done2;
            4:       return done4;
            default: return done8;
        endcase
    endfunction

    function automatic logic sel_busy(input int rpc);
        case (rpc)
            1:       return busy1;
            2:       return busy2;
            4:       return busy4;
            default: return busy8;
        endcase
    endfunction

    function automatic logic sel_meets(input int rpc);
        case (rpc)
            1:       return meets1;
            2:       return meets2;
            4:       return meets4;
            default: return meets8;
        endcase
    endfunction

    function automatic logic [255:0] sel_digest(input int rpc);
        case (rpc)
            1:       return digest1;
            2:       return digest2;
            4:       return digest4;
            default: return digest8;
        endcase
    endfunction

    // Called 1 time unit after a rising edge; returns in the done cycle (or after a 200-cycle bound).
    task automatic run_op(input int rpc, input logic [511:0] blk, input logic [255:0] tgt,
                          output int lat, output logic [255:0] dg, output logic mt, output logic bz);
        block_in = blk;
        h_in     = IV;
        target   = tgt;
        set_start(rpc, 1'b1);
        @(posedge clk); #1;
        set_start(rpc, 1'b0);
        block_in = '1;
        h_in     = '0;
        lat = -1; dg = '0; mt = 1'b0; bz = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (sel_done(rpc)) begin
                lat = c;
                dg  = sel_digest(rpc);
                mt  = sel_meets(rpc);
                bz  = sel_busy(rpc);
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy1); end
        n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done1); end
        n_checks++; if (digest1 !== 256'h0) begin n_fail++; $display("FAIL reset_digest: got %h expected 0", digest1); end
        n_checks++; if (meets1 !== 1'b0) begin n_fail++; $display("FAIL reset_meets: got %b expected 0", meets1); end
    endtask

    task automatic test_abc();
        int lat; logic [255:0] dg; logic mt, bz;
        run_op(1, BLK_ABC, '0, lat, dg, mt, bz);
        n_checks++; if (lat !== 65) begin n_fail++; $display("FAIL abc_latency: got %0d expected 65", lat); end
        n_checks++; if (dg !== ABC_DIG) begin n_fail++; $display("FAIL abc_digest: got %h expected %h", dg, ABC_DIG); end
        n_checks++; if (bz !== 1'b0) begin n_fail++; $display("FAIL abc_busy_in_done: got %b expected 0", bz); end
        @(posedge clk); #1;
        n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL abc_done_width: got %b expected 0", done1); end
    endtask

    task automatic test_empty();
        int lat; logic [255:0] dg; logic mt, bz;
        for (int k = 0; k < 3; k++) begin
            int rpc;
            rpc = (k == 0) ? 4 : (k == 1) ? 2 : 8;
            run_op(rpc, BLK_EMPTY, '0, lat, dg, mt, bz);
            n_checks++;
            if (lat !== 64 / rpc + 1) begin
                n_fail++; $display("FAIL empty_latency_r%0d: got %0d expected %0d", rpc, lat, 64 / rpc + 1);
            end
            n_checks++;
            if (dg !== EMPTY_DIG) begin
                n_fail++; $display("FAIL empty_digest_r%0d: got %h expected %h", rpc, dg, EMPTY_DIG);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        block_in = BLK_ABC;
        h_in     = IV;
        start1   = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_after_start: got %b expected 1", busy1); end
        lat1 = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (done1) begin lat1 = c; break; end
        end
        n_checks++; if (lat1 !== 65) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 65", lat1); end
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_in_done: got %b expected 0", busy1); end
        @(posedge clk); #1;
        n_checks++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_restart: got busy=%b done=%b expected busy=1 done=0", busy1, done1);
        end
        start1 = 1'b0;
        lat2 = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (done1) begin lat2 = c; break; end
        end
        n_checks++; if (lat2 !== 65) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 65", lat2); end
        n_checks++; if (digest1 !== ABC_DIG) begin n_fail++; $display("FAIL b2b_digest: got %h expected %h", digest1, ABC_DIG); end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int seen_done;
        block_in = BLK_EMPTY;
        h_in     = IV;
        start1   = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (9) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy1); end
        seen_done = 0;
        for (int c = 0; c < 80; c++) begin
            if (done1) seen_done++;
            @(posedge clk); #1;
        end
        n_checks++; if (seen_done !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen_done); end
        n_checks++; if (digest1 !== ABC_DIG) begin n_fail++; $display("FAIL abort_digest_kept: got %h expected %h", digest1, ABC_DIG); end
        // abort in IDLE wins over a simultaneous start
        start1 = 1'b1;
        abort  = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        abort  = 1'b0;
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL idle_abort_beats_start: got %b expected 0", busy1); end
        @(posedge clk); #1;
    endtask

    task automatic test_target();
        int lat; logic [255:0] dg; logic mt, bz;
        logic [255:0] tgts [3];
        logic         exp_mt [3];
        tgts[0] = ABC_DIG;
        tgts[1] = ABC_DIG - 256'd1;
        tgts[2] = '1;
`ifdef SHA_TARGET_CMP_EN
        exp_mt[0] = 1'b1; exp_mt[1] = 1'b0; exp_mt[2] = 1'b1;
`else
        exp_mt[0] = 1'b0; exp_mt[1] = 1'b0; exp_mt[2] = 1'b0;
`endif
        for (int k = 0; k < 3; k++) begin
            run_op(1, BLK_ABC, tgts[k], lat, dg, mt, bz);
            n_checks++;
            if (mt !== exp_mt[k] || lat !== 65) begin
                n_fail++; $display("FAIL target_case%0d: got meets=%b lat=%0d expected meets=%b lat=65", k, mt, lat, exp_mt[k]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midrun();
        int lat; logic [255:0] dg; logic mt, bz;
        block_in = BLK_ABC;
        h_in     = IV;
        start1   = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (19) @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        n_checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || digest1 !== 256'h0 || meets1 !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: got busy=%b done=%b meets=%b digest=%h expected all 0", busy1, done1, meets1, digest1);
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        run_op(1, BLK_ABC, '0, lat, dg, mt, bz);
        n_checks++;
        if (dg !== ABC_DIG || lat !== 65) begin
            n_fail++; $display("FAIL post_reset_abc: got lat=%0d digest=%h expected lat=65 digest=%h", lat, dg, ABC_DIG);
        end
    endtask

    initial begin
        n_rst    = 1'b0;
        abort    = 1'b0;
        start1   = 1'b0;
        start2   = 1'b0;
        start4   = 1'b0;
        start8   = 1'b0;
        block_in = '0;
        h_in     = '0;
        target   = '0;
        #1;
        test_reset();
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        @(posedge clk); #1;
        test_abc();
        test_empty();
        test_back_to_back();
        test_abort();
        test_target();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
